// File: rtl/psum_accum_sched_if.sv
// Requester/downstream handshake bundle for psum_accum_sched.
// The sat_flag member exists only when PSUM_SAT_EN is defined.
interface psum_accum_sched_if #(
    parameter int PWIDTH = 47,
    parameter int NREQ   = 4,
    parameter int IDW    = $clog2(NREQ)
);
    logic [NREQ-1:0]        in_valid;
    logic [NREQ*PWIDTH-1:0] in_data;
    logic [NREQ-1:0]        in_ready;
    logic                   out_valid;
    logic [PWIDTH-1:0]      out_data;
    logic                   out_ready;
    logic [IDW-1:0]         out_src;
    logic                   busy;
`ifdef PSUM_SAT_EN
    logic                   sat_flag;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_src, busy, sat_flag
    );
    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_src, busy, sat_flag
    );
`else
    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_src, busy
    );
    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_src, busy
    );
`endif
endinterface

// File: rtl/psum_accum_sched.sv
// Round-robin scheduler sharing one psum adder across NREQ requesters, ACC_LEN psums per result.
// Optional macro PSUM_SAT_EN: saturating accumulation plus a sat_flag output.
module psum_accum_sched #(
    parameter int DWIDTH  = 8,
    parameter int PWIDTH  = 47,
    parameter int NREQ    = 4,
    parameter int ACC_LEN = 5,
    parameter int IDW     = $clog2(NREQ)
) (
    input  logic              clk,
    input  logic              reset,
    psum_accum_sched_if.slave bus
);
    localparam int HW = PWIDTH - DWIDTH*5;
    localparam int CW = (ACC_LEN > 1) ? $clog2(ACC_LEN) : 1;
    localparam int SW = $clog2(NREQ*PWIDTH);

    typedef enum logic [1:0] {IDLE, ADD, EMIT} state_t;

    state_t            state_q, state_d;
    logic [IDW-1:0]    rr_ptr_q, rr_ptr_d;
    logic [IDW-1:0]    gnt_id_q, gnt_id_d;
    logic [DWIDTH-1:0] psum_q, psum_d;
    logic [HW-1:0]     hdr_q, hdr_d;
    logic [DWIDTH-1:0] acc_q [NREQ];
    logic [DWIDTH-1:0] acc_d [NREQ];
    logic [CW-1:0]     cnt_q [NREQ];
    logic [CW-1:0]     cnt_d [NREQ];
    logic              out_valid_q, out_valid_d;
    logic [PWIDTH-1:0] out_data_q, out_data_d;
    logic [IDW-1:0]    out_src_q, out_src_d;

    logic              grant_found;
    logic [IDW-1:0]    grant_id;
    logic [IDW:0]      scan_wide;
    logic [IDW-1:0]    scan_idx;
    logic [SW-1:0]     pkt_base;
    logic [DWIDTH-1:0] sum;

`ifdef PSUM_SAT_EN
    logic [DWIDTH:0]   sum_wide;
    logic              sat_hit;
    logic              sat_q [NREQ];
    logic              sat_d [NREQ];
    logic              sat_flag_q, sat_flag_d;
`endif

    // First valid requester at or after rr_ptr, wrapping at NREQ.
    always_comb begin
        grant_found = 1'b0;
        grant_id    = '0;
        scan_wide   = '0;
        scan_idx    = '0;
        for (int k = 0; k < NREQ; k++) begin
            scan_wide = {1'b0, rr_ptr_q} + (IDW+1)'(k);
            scan_idx  = (scan_wide >= (IDW+1)'(NREQ)) ? IDW'(scan_wide - (IDW+1)'(NREQ))
                                                      : IDW'(scan_wide);
            if (!grant_found && bus.in_valid[scan_idx]) begin
                grant_found = 1'b1;
                grant_id    = scan_idx;
            end
        end
    end

    always_comb begin
        bus.in_ready = '0;
        if (state_q == IDLE && grant_found && !reset) begin
            bus.in_ready[grant_id] = 1'b1;
        end
    end

`ifdef PSUM_SAT_EN
    always_comb begin
        sum_wide = {1'b0, acc_q[gnt_id_q]} + {1'b0, psum_q};
        sat_hit  = sum_wide[DWIDTH] | sat_q[gnt_id_q];
        sum      = sat_hit ? '1 : sum_wide[DWIDTH-1:0];
    end
`else
    always_comb begin
        sum = acc_q[gnt_id_q] + psum_q;
    end
`endif

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        gnt_id_d    = gnt_id_q;
        psum_d      = psum_q;
        hdr_d       = hdr_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_src_d   = out_src_q;
        pkt_base    = SW'(grant_id) * SW'(PWIDTH);
`ifdef PSUM_SAT_EN
        sat_d       = sat_q;
        sat_flag_d  = sat_flag_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (grant_found) begin
                    psum_d   = bus.in_data[pkt_base +: DWIDTH];
                    hdr_d    = bus.in_data[pkt_base + SW'(DWIDTH*5) +: HW];
                    gnt_id_d = grant_id;
                    rr_ptr_d = (grant_id == IDW'(NREQ-1)) ? '0 : grant_id + 1'b1;
                    state_d  = ADD;
                end
            end
            ADD: begin
                if (cnt_q[gnt_id_q] == CW'(ACC_LEN-1)) begin
                    out_data_d      = {hdr_q, {(DWIDTH*4){1'b0}}, sum};
                    out_src_d       = gnt_id_q;
                    out_valid_d     = 1'b1;
                    acc_d[gnt_id_q] = '0;
                    cnt_d[gnt_id_q] = '0;
`ifdef PSUM_SAT_EN
                    sat_flag_d      = sat_hit;
                    sat_d[gnt_id_q] = 1'b0;
`endif
                    state_d         = EMIT;
                end else begin
                    acc_d[gnt_id_q] = sum;
                    cnt_d[gnt_id_q] = cnt_q[gnt_id_q] + 1'b1;
`ifdef PSUM_SAT_EN
                    sat_d[gnt_id_q] = sat_hit;
`endif
                    state_d         = IDLE;
                end
            end
            EMIT: begin
                if (bus.out_ready) begin
                    out_valid_d = 1'b0;
`ifdef PSUM_SAT_EN
                    sat_flag_d  = 1'b0;
`endif
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Reset also drops any latched packet and every partial sum.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            rr_ptr_q    <= '0;
            gnt_id_q    <= '0;
            psum_q      <= '0;
            hdr_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_src_q   <= '0;
            for (int i = 0; i < NREQ; i++) begin
                acc_q[i] <= '0;
                cnt_q[i] <= '0;
`ifdef PSUM_SAT_EN
                sat_q[i] <= 1'b0;
`endif
            end
`ifdef PSUM_SAT_EN
            sat_flag_q  <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            gnt_id_q    <= gnt_id_d;
            psum_q      <= psum_d;
            hdr_q       <= hdr_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_src_q   <= out_src_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
`ifdef PSUM_SAT_EN
            sat_q       <= sat_d;
            sat_flag_q  <= sat_flag_d;
`endif
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_src   = out_src_q;
    assign bus.busy      = (state_q != IDLE);
`ifdef PSUM_SAT_EN
    assign bus.sat_flag  = sat_flag_q;
`endif

endmodule

// File: tb/tb_psum_accum_sched.sv
// Scoreboard bench for psum_accum_sched: default ACC_LEN=5 instance plus an ACC_LEN=1 instance.
// Expected values follow PSUM_SAT_EN when the macro is defined.
module tb_psum_accum_sched;
    localparam int DWIDTH = 8;
    localparam int PWIDTH = 47;
    localparam int NREQ   = 4;
    localparam int HW     = PWIDTH - DWIDTH*5;
    localparam int ACCLEN = 5;

    typedef struct packed {
        logic [PWIDTH-1:0] data;
        logic [1:0]        src;
        logic              sat;
    } result_t;

    logic clk = 1'b0;
    logic reset;
    int   errors = 0;
    int   checks = 0;

    result_t           expQ[$];
    int unsigned       modelAcc [NREQ];
    int                modelCnt [NREQ];
    bit                modelSat [NREQ];
    logic [PWIDTH-1:0] lastData;
    logic [1:0]        lastSrc;
    logic              lastSat;
    int                resultCount = 0;
    int                srcLog[$];

    always #5 clk = ~clk;

    psum_accum_sched_if #(.PWIDTH(PWIDTH), .NREQ(NREQ)) bus ();
    psum_accum_sched_if #(.PWIDTH(PWIDTH), .NREQ(NREQ)) bus1 ();

    psum_accum_sched #(.DWIDTH(DWIDTH), .PWIDTH(PWIDTH), .NREQ(NREQ), .ACC_LEN(ACCLEN)) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );

    psum_accum_sched #(.DWIDTH(DWIDTH), .PWIDTH(PWIDTH), .NREQ(NREQ), .ACC_LEN(1)) dut1 (
        .clk(clk), .reset(reset), .bus(bus1)
    );

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Reference accumulation: pushes the expected packet when a requester's final psum is taken.
    function automatic void modelAccept(input int i, input logic [PWIDTH-1:0] pkt);
        int unsigned s;
        result_t r;
        s = modelAcc[i] + int'(pkt[DWIDTH-1:0]);
`ifdef PSUM_SAT_EN
        if (s > 255 || modelSat[i]) begin
            s = 255;
            modelSat[i] = 1'b1;
        end
`else
        s = s % 256;
`endif
        modelCnt[i]++;
        if (modelCnt[i] == ACCLEN) begin
            r.data = {pkt[PWIDTH-1 -: HW], 32'h0, s[7:0]};
            r.src  = i[1:0];
            r.sat  = modelSat[i];
            expQ.push_back(r);
            modelAcc[i] = 0;
            modelCnt[i] = 0;
            modelSat[i] = 1'b0;
        end else begin
            modelAcc[i] = s;
        end
    endfunction

    always @(negedge clk) begin
        result_t e;
        if (reset) begin
            expQ.delete();
            for (int i = 0; i < NREQ; i++) begin
                modelAcc[i] = 0;
                modelCnt[i] = 0;
                modelSat[i] = 1'b0;
            end
        end else begin
            for (int i = 0; i < NREQ; i++) begin
                if (bus.in_valid[i] && bus.in_ready[i]) modelAccept(i, bus.in_data[i*PWIDTH +: PWIDTH]);
            end
            if (bus.out_valid && bus.out_ready) begin
                if (expQ.size() == 0) begin
                    checkOutput("unexpected_result", 64'(bus.out_data), 64'h0);
                end else begin
                    e = expQ.pop_front();
                    checkOutput("result_data", 64'(bus.out_data), 64'(e.data));
                    checkOutput("result_src", 64'(bus.out_src), 64'(e.src));
`ifdef PSUM_SAT_EN
                    checkOutput("result_sat", 64'(bus.sat_flag), 64'(e.sat));
                    lastSat = bus.sat_flag;
`endif
                end
                lastData = bus.out_data;
                lastSrc  = bus.out_src;
                resultCount++;
                srcLog.push_back(int'(bus.out_src));
            end
        end
    end

    // Hold one requester's packet valid until it is accepted; returns just after the accept edge.
    task automatic applyStimulus(input int req, input logic [7:0] psum, input logic [6:0] hdr);
        int  waitCycles = 0;
        bit  done = 1'b0;
        bus.in_data[req*PWIDTH +: PWIDTH] = {hdr, $urandom(), psum};
        bus.in_valid[req] = 1'b1;
        while (!done) begin
            @(negedge clk);
            if (bus.in_ready[req]) begin
                done = 1'b1;
            end else if (++waitCycles > 200) begin
                checkOutput("accept_timeout", 64'(req), 64'hFF);
                done = 1'b1;
            end
        end
        @(posedge clk);
        #1;
        bus.in_valid[req] = 1'b0;
    endtask

    task automatic waitDrain();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while ((expQ.size() != 0 || bus.busy) && n < 200);
        if (n >= 200) checkOutput("drain_timeout", 64'(expQ.size()), 64'h0);
        @(posedge clk);
        #1;
    endtask

    task automatic resetDut(input string tag);
        reset = 1'b1;
        @(posedge clk);
        #1;
        checkOutput({tag, "_out_valid"}, 64'(bus.out_valid), 64'h0);
        checkOutput({tag, "_out_data"}, 64'(bus.out_data), 64'h0);
        checkOutput({tag, "_out_src"}, 64'(bus.out_src), 64'h0);
        checkOutput({tag, "_in_ready"}, 64'(bus.in_ready), 64'h0);
        checkOutput({tag, "_busy"}, 64'(bus.busy), 64'h0);
        reset = 1'b0;
    endtask

    task automatic sendAcc1(input logic [7:0] psum, input logic [6:0] hdr);
        int n = 0;
        bus1.in_data[3*PWIDTH +: PWIDTH] = {hdr, 32'h12345678, psum};
        bus1.in_valid[3] = 1'b1;
        do begin
            @(negedge clk);
            n++;
        end while (!bus1.in_ready[3] && n < 50);
        checkOutput("t6_accept", 64'(bus1.in_ready), 64'h8);
        @(posedge clk);
        #1;
        bus1.in_valid[3] = 1'b0;
        @(negedge clk);
        checkOutput("t6_not_yet", 64'(bus1.out_valid), 64'h0);
        @(negedge clk);
        checkOutput("t6_valid", 64'(bus1.out_valid), 64'h1);
        checkOutput("t6_data", 64'(bus1.out_data), 64'({hdr, 32'h0, psum}));
        checkOutput("t6_src", 64'(bus1.out_src), 64'h3);
        @(posedge clk);
        #1;
        checkOutput("t6_valid_drop", 64'(bus1.out_valid), 64'h0);
    endtask

    initial begin
        int startCount;
        int srcStart;
        int expGrant;
        int accepts;
        int n;

        reset          = 1'b1;
        bus.in_valid   = '0;
        bus.in_data    = '0;
        bus.out_ready  = 1'b1;
        bus1.in_valid  = '0;
        bus1.in_data   = '0;
        bus1.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_out_valid", 64'(bus.out_valid), 64'h0);
        checkOutput("rst_out_data", 64'(bus.out_data), 64'h0);
        checkOutput("rst_busy", 64'(bus.busy), 64'h0);
        reset = 1'b0;

        $display("[TB] single requester accumulation");
        startCount = resultCount;
        applyStimulus(0, 8'd10, 7'h2A);
        applyStimulus(0, 8'd20, 7'h2A);
        applyStimulus(0, 8'd30, 7'h2A);
        applyStimulus(0, 8'd40, 7'h2A);
        applyStimulus(0, 8'd50, 7'h2A);
        waitDrain();
        checkOutput("t1_count", 64'(resultCount - startCount), 64'd1);
        checkOutput("t1_sum", 64'(lastData[7:0]), 64'd150);
        checkOutput("t1_mid", 64'(lastData[39:8]), 64'h0);
        checkOutput("t1_hdr", 64'(lastData[46:40]), 64'h2A);
        checkOutput("t1_src", 64'(lastSrc), 64'h0);

        $display("[TB] overflow on requester 1");
        for (int k = 0; k < 5; k++) applyStimulus(1, 8'd100, 7'h11);
        waitDrain();
`ifdef PSUM_SAT_EN
        checkOutput("t2_sum", 64'(lastData[7:0]), 64'd255);
        checkOutput("t2_sat", 64'(lastSat), 64'h1);
`else
        checkOutput("t2_sum", 64'(lastData[7:0]), 64'd244);
`endif
        checkOutput("t2_src", 64'(lastSrc), 64'h1);

        $display("[TB] round-robin with all requesters valid");
        resetDut("t3_rst");
        for (int i = 0; i < NREQ; i++) bus.in_data[i*PWIDTH +: PWIDTH] = {7'(i), 32'hDEADBEEF, 8'd1};
        bus.in_valid = '1;
        expGrant   = 0;
        accepts    = 0;
        n          = 0;
        startCount = resultCount;
        srcStart   = srcLog.size();
        while (accepts < 20 && n < 400) begin
            @(negedge clk);
            n++;
            if (!bus.busy) begin
                checkOutput("t3_grant", 64'(bus.in_ready), 64'(4'b0001 << expGrant));
                if (bus.in_ready != 0) begin
                    accepts++;
                    expGrant = (expGrant + 1) % NREQ;
                end
            end else begin
                checkOutput("t3_busy_ready", 64'(bus.in_ready), 64'h0);
            end
        end
        @(posedge clk);
        #1;
        bus.in_valid = '0;
        if (accepts < 20) checkOutput("t3_timeout", 64'(accepts), 64'd20);
        waitDrain();
        checkOutput("t3_count", 64'(resultCount - startCount), 64'd4);
        for (int k = 0; k < 4; k++) begin
            if (srcLog.size() > srcStart + k) checkOutput("t3_src_order", 64'(srcLog[srcStart+k]), 64'(k));
        end
        checkOutput("t3_last_sum", 64'(lastData[7:0]), 64'd5);

        $display("[TB] downstream stall");
        bus.out_ready = 1'b0;
        for (int k = 1; k <= 5; k++) applyStimulus(3, 8'(k), 7'h55);
        @(posedge clk);
        #1;
        bus.in_data[0 +: PWIDTH] = {7'h01, 32'h0, 8'd7};
        bus.in_valid[0] = 1'b1;
        repeat (10) begin
            @(negedge clk);
            checkOutput("t4_valid", 64'(bus.out_valid), 64'h1);
            checkOutput("t4_data", 64'(bus.out_data), 64'({7'h55, 32'h0, 8'd15}));
            checkOutput("t4_src", 64'(bus.out_src), 64'h3);
            checkOutput("t4_ready", 64'(bus.in_ready), 64'h0);
        end
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        checkOutput("t4_next_accept", 64'(bus.in_ready), 64'h1);
        @(posedge clk);
        #1;
        bus.in_valid[0] = 1'b0;
        waitDrain();

        $display("[TB] reset mid-accumulation");
        for (int k = 0; k < 3; k++) applyStimulus(2, 8'd9, 7'h33);
        bus.in_valid[0] = 1'b1;
        resetDut("t5_rst");
        bus.in_valid[0] = 1'b0;
        startCount = resultCount;
        for (int k = 0; k < 5; k++) applyStimulus(2, 8'd1, 7'h33);
        waitDrain();
        checkOutput("t5_count", 64'(resultCount - startCount), 64'd1);
        checkOutput("t5_sum", 64'(lastData[7:0]), 64'd5);
        checkOutput("t5_src", 64'(lastSrc), 64'h2);

        $display("[TB] ACC_LEN=1 instance");
        sendAcc1(8'd3, 7'h44);
        sendAcc1(8'd4, 7'h45);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
